// File: rtl/coef_load_ctrl.sv
// Write-side sequencer: streams FIR coefficients into TM banks of 2^AW words.
// Optional COEF_LOAD_TLAST_CHECK_EN enables s_tlast vs load_len consistency checking.
module coef_load_ctrl #(
  parameter  int unsigned COEFW = 18,
  parameter  int unsigned AW    = 7,
  parameter  int unsigned TM    = 2,
  localparam int unsigned BW    = (TM > 1) ? $clog2(TM) : 1,
  localparam int unsigned LW    = AW + BW + 1
) (
  input  logic             clkw,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [LW-1:0]    load_len,
  input  logic [COEFW-1:0] s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [COEFW-1:0] coef_write,
  output logic [AW-1:0]    coef_write_addr,
  output logic [TM-1:0]    coef_write_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LW-1:0] MAX_LEN = LW'(TM << AW);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    len_q, len_d;
  logic [COEFW-1:0] wdata_q, wdata_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [TM-1:0]    wen_q, wen_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept_c;
  logic             last_c;
  logic [TM-1:0]    bank_oh_c;

  // Ready is combinational so abort blocks the handshake in its own cycle.
  assign s_tready  = (state_q == S_LOAD) & ~abort;
  assign accept_c  = s_tvalid & s_tready;
  assign last_c    = (cnt_q == (len_q - LW'(1)));
  assign bank_oh_c = TM'(1) << cnt_q[AW+BW-1:AW];

`ifndef COEF_LOAD_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = s_tlast;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    wen_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((load_len == '0) || (load_len > MAX_LEN)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            len_d   = load_len;
            cnt_d   = '0;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept_c) begin
          wdata_d = s_tdata;
          waddr_d = cnt_q[AW-1:0];
          wen_d   = bank_oh_c;
          cnt_d   = cnt_q + LW'(1);
`ifdef COEF_LOAD_TLAST_CHECK_EN
          // Early or missing tlast still writes the beat, then ends the load with err.
          if (s_tlast != last_c) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (last_c) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`else
          if (last_c) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkw or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      wen_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign coef_write      = wdata_q;
  assign coef_write_addr = waddr_q;
  assign coef_write_en   = wen_q;
  assign busy            = (state_q == S_LOAD);
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: doc/coef_load_ctrl.md
# coef_load_ctrl

Write-side sequencer that loads FIR coefficients from a valid/ready stream into a bank of TM `coef_multplx` instances. It generates the shared `coef_write`/`coef_write_addr` bus and one write enable per bank, walking the banks in order. It runs in the write clock domain and reports completion and error status to the host.

## Interface

Parameters:
- COEFW, 18, coefficient width; matches `coef_multplx` COEFW.
- AW, 7, per-bank write address width; each bank holds 2^AW words.
- TM, 2, number of coefficient banks (>=1); BW = max(1, clog2(TM)).
- LW = AW+BW+1, width of the length and counter fields.

Ports:
- clkw, input, 1, write clock; all logic is on its rising edge.
- rstn, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle load request.
- abort, input, 1, synchronous cancel of a load in progress.
- load_len, input, LW, number of coefficients to load; sampled when start is accepted.
- s_tdata, input, COEFW, coefficient stream data (signed).
- s_tvalid, input, 1, stream valid.
- s_tlast, input, 1, stream end marker.
- s_tready, output, 1, stream ready.
- coef_write, output, COEFW, write data to all banks.
- coef_write_addr, output, AW, write address to all banks.
- coef_write_en, output, TM, one-hot write enable, one bit per bank.
- busy, output, 1, high while a load is in progress.
- done, output, 1, one-cycle pulse on successful completion.
- err, output, 1, one-cycle pulse on any error.

## Operation

- States:
  - IDLE: waiting for a request.
  - LOAD: accepting stream beats.
- busy = (state == LOAD).
- IDLE -> LOAD on start when 1 <= load_len <= TM·2^AW. The length is latched and the beat counter cnt is cleared.
- start with load_len = 0 or load_len > TM·2^AW: err pulses next cycle and the block stays in IDLE.
- start while in LOAD is ignored.
- s_tready = (state == LOAD) & ~abort. This is combinational, so abort blocks the handshake in the same cycle.
- Accept = s_tvalid & s_tready. For each accepted beat:
  - s_tdata is registered to coef_write.
  - cnt[AW-1:0] is registered to coef_write_addr.
  - coef_write_en is registered as a one-hot at bank index cnt[AW+BW-1:AW].
  - cnt increments.
- Bank order: bank 0 addresses 0..2^AW-1, then bank 1 from address 0, and so on. The address wraps to 0 at each bank boundary.
- Final beat (cnt == len-1 at accept): LOAD -> IDLE, and done pulses.
- abort in LOAD: LOAD -> IDLE next cycle. No done, no err, and no further writes. Banks keep any words already written.
- abort in IDLE: no effect.
- s_tvalid low in LOAD: the block waits indefinitely; stalls are allowed.
- Outputs go to 0 on reset:
  - coef_write, coef_write_addr, coef_write_en, done, err, busy.
  - State returns to IDLE.
- coef_write_en is 0 in every cycle that does not follow an accept.
- Reset asserted mid-load: all outputs clear immediately (asynchronously). No write is issued after the reset edge.

## Timing

- Write latency: one cycle from accept to coef_write_en/addr/data valid. The bank captures the word on the following clkw edge.
- busy rises the cycle after start is sampled.
- busy falls in the same cycle that the final coef_write_en is high.
- done pulses in that same cycle.
- Throughput: one coefficient per clkw cycle with s_tvalid held high.
- A load of N beats with no stalls: busy is high for N cycles.
- Back-to-back loads: start is accepted in the cycle busy is low. At the earliest this is the cycle done is high, which gives one dead cycle between loads.
- err is always a one-cycle pulse, registered.

## Configuration

- COEF_LOAD_TLAST_CHECK_EN defined:
  - s_tlast on a beat other than the final one: the beat is written, err pulses, the block goes to IDLE, and there is no done.
  - Final beat without s_tlast: the beat is written, err pulses instead of done, and the block goes to IDLE.
- COEF_LOAD_TLAST_CHECK_EN undefined: s_tlast is ignored and only load_len terminates the load.

## Test plan

- Reset, AW=7, TM=2:
  - Stimulus: load_len=256, continuous beats with s_tdata = index, s_tlast on beat 255.
  - Required: bank 0 gets addresses 0..127 with data 0..127; bank 1 gets addresses 0..127 with data 128..255; one done pulse; busy high for exactly 256 cycles.
- load_len=5 with s_tvalid toggled every other cycle:
  - Required: exactly 5 single-bit coef_write_en pulses, at addresses 0..4 of bank 0, each one cycle after its accept; done after the 5th.
- Range checks:
  - load_len=0 -> err pulse, busy stays 0.
  - load_len=257 -> err pulse, busy stays 0.
  - start during an active load -> ignored; the load completes normally.
- Abort: load_len=100, abort asserted after 40 accepts, with s_tvalid held high in the abort cycle.
  - Required: s_tready is 0 in that cycle; exactly 40 writes; no done, no err; busy low next cycle.
- With COEF_LOAD_TLAST_CHECK_EN defined: load_len=10 with s_tlast on beat 6.
  - Required: 7 writes, err pulse, no done.
  - Repeat without the macro: 10 writes and done.
- rstn pulsed low at beat 20 of a 50-beat load:
  - Required: all outputs are 0 asynchronously, the block is IDLE, and no coef_write_en appears afterwards.
  - A new start with load_len=3 then works correctly from address 0 of bank 0.
